// File: rtl/dwt_fetch_sequencer.sv
// Fetch sequencer for one lifting-DWT level: reads x[2n], x[2n+1], x[2n+2] per pair
// from sample RAM and hands them, with the dwt operand selects, to the datapath.
module dwt_fetch_sequencer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int N_SAMPLES = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] y2n,
    output logic [DATA_W-1:0] y2n_1,
    output logic [DATA_W-1:0] y2na,
    output logic [1:0]        s1,
    output logic              s2,
    output logic              s3,
    output logic              s4,
    output logic              s5,
    output logic              s6,
    output logic [ADDR_W-1:0] pair_idx,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int N_PAIRS = N_SAMPLES / 2;
    localparam logic [ADDR_W:0]   FRAME_LEN   = (ADDR_W + 1)'(N_SAMPLES);
    localparam logic [ADDR_W-1:0] MIRROR_ADDR = ADDR_W'(N_SAMPLES - 2);
    localparam logic [ADDR_W-1:0] LAST_PAIR   = ADDR_W'(N_PAIRS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH0,
        FETCH1,
        FETCH2,
        CAPT,
        PRESENT,
        DONE
    } state_t;

    state_t state;
    logic   mirror;

    logic [ADDR_W:0]   even_wide;
    logic [ADDR_W-1:0] even_addr;
    logic              wrap;
    logic              first_pair;
    logic              last_pair;

    // 2n+2 is formed one bit wider so the frame-end test survives N_SAMPLES == 2**ADDR_W
    assign even_wide  = {pair_idx, 1'b0};
    assign even_addr  = pair_idx << 1;
    assign wrap       = (even_wide + (ADDR_W + 1)'(2)) == FRAME_LEN;
    assign first_pair = pair_idx == '0;
    assign last_pair  = pair_idx == LAST_PAIR;

    assign s2 = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            y2n       <= '0;
            y2n_1     <= '0;
            y2na      <= '0;
            s1        <= 2'b00;
            s3        <= 1'b0;
            s4        <= 1'b0;
            s5        <= 1'b0;
            s6        <= 1'b0;
            pair_idx  <= '0;
            out_valid <= 1'b0;
            mirror    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= FETCH0;
                        busy      <= 1'b1;
                        pair_idx  <= '0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= '0;
                        s6        <= 1'b1;
                    end
                end
                FETCH0: begin
                    state    <= FETCH1;
                    s6       <= 1'b0;
                    mem_addr <= even_addr + ADDR_W'(1);
                end
                FETCH1: begin
                    state    <= FETCH2;
                    y2n      <= mem_rdata;
                    mirror   <= wrap;
                    mem_addr <= wrap ? MIRROR_ADDR : even_addr + ADDR_W'(2);
                end
                FETCH2: begin
                    state     <= CAPT;
                    y2n_1     <= mem_rdata;
                    mem_rd_en <= 1'b0;
                end
                CAPT: begin
                    state     <= PRESENT;
                    y2na      <= mem_rdata;
                    out_valid <= 1'b1;
                    s1        <= {last_pair, first_pair};
                    s3        <= first_pair;
                    s4        <= last_pair;
                    s5        <= mirror;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        s1        <= 2'b00;
                        s3        <= 1'b0;
                        s4        <= 1'b0;
                        s5        <= 1'b0;
                        if (last_pair) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= FETCH0;
                            pair_idx  <= pair_idx + ADDR_W'(1);
                            mem_rd_en <= 1'b1;
                            mem_addr  <= even_addr + ADDR_W'(2);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dwt_fetch_sequencer.sv
// Bench for dwt_fetch_sequencer: random frames and backpressure against a pair-level
// reference model, plus an N_SAMPLES=2 instance for the single-pair corner.
module tb_dwt_fetch_sequencer;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NS = 8;
    localparam int NP = NS / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, out_ready;
    logic          busy, done, mem_rd_en, out_valid;
    logic [AW-1:0] mem_addr, pair_idx;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] y2n, y2n_1, y2na;
    logic [1:0]    s1;
    logic          s2, s3, s4, s5, s6;

    logic          start_b, out_ready_b;
    logic          busy_b, done_b, mem_rd_en_b, out_valid_b;
    logic [AW-1:0] mem_addr_b, pair_idx_b;
    logic [DW-1:0] mem_rdata_b = '0;
    logic [DW-1:0] y2n_b, y2n_1_b, y2na_b;
    logic [1:0]    s1_b;
    logic          s2_b, s3_b, s4_b, s5_b, s6_b;

    logic [DW-1:0] ram [1024];

    always @(posedge clk) begin
        if (mem_rd_en)   mem_rdata   <= ram[mem_addr];
        if (mem_rd_en_b) mem_rdata_b <= ram[mem_addr_b];
    end

    dwt_fetch_sequencer #(.DATA_W(DW), .ADDR_W(AW), .N_SAMPLES(NS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .y2n(y2n), .y2n_1(y2n_1), .y2na(y2na), .s1(s1), .s2(s2), .s3(s3), .s4(s4),
        .s5(s5), .s6(s6), .pair_idx(pair_idx), .out_valid(out_valid), .out_ready(out_ready)
    );

    dwt_fetch_sequencer #(.DATA_W(DW), .ADDR_W(AW), .N_SAMPLES(2)) dut_single (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
        .y2n(y2n_b), .y2n_1(y2n_1_b), .y2na(y2na_b), .s1(s1_b), .s2(s2_b), .s3(s3_b),
        .s4(s4_b), .s5(s5_b), .s6(s6_b), .pair_idx(pair_idx_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b)
    );

    int tests  = 0;
    int failed = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, " strobes"}, 64'({busy, done, mem_rd_en, out_valid, s2, s3, s4, s5, s6}), 64'(0));
        checkOutput({tag, " addr"}, 64'(mem_addr), 64'(0));
        checkOutput({tag, " pair_idx"}, 64'(pair_idx), 64'(0));
        checkOutput({tag, " data"}, 64'(y2n | y2n_1 | y2na), 64'(0));
        checkOutput({tag, " s1"}, 64'(s1), 64'(0));
    endtask

    // mode 0: ramp data, ready high; 1: random data and ready; 2: 7-cycle stall on pair 1
    task automatic applyStimulus(input int mode, input bit holdStart);
        int            expAddr[$];
        int            gotAddr[$];
        logic [DW-1:0] ey0[NP], ey1[NP], eya[NP];
        int            n = 0, stalls = 0, firstValid = -1, doneCycle = -1;
        int            s6Count = 0, s6At = -1;
        bit            held = 0, sawRead = 0, sawDone = 0, sawBusy = 0;
        logic [DW-1:0] hy0 = '0, hy1 = '0, hya = '0;
        logic [1:0]    hs1 = '0;
        logic [AW-1:0] hpi = '0;

        for (int i = 0; i < NS; i++) ram[i] = (mode == 0) ? DW'(i + 1) : $urandom;
        for (int p = 0; p < NP; p++) begin
            int na;
            na     = (2 * p + 2 < NS) ? 2 * p + 2 : NS - 2;
            ey0[p] = ram[2 * p];
            ey1[p] = ram[2 * p + 1];
            eya[p] = ram[na];
            expAddr.push_back(2 * p);
            expAddr.push_back(2 * p + 1);
            expAddr.push_back(na);
        end

        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        if (!holdStart) start = 1'b0;

        for (int cyc = 1; cyc <= 300 && doneCycle < 0; cyc++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = !(n == 1 && stalls < 7);
            endcase
            @(negedge clk);
            if (mem_rd_en) gotAddr.push_back(int'(mem_addr));
            if (s6) begin s6Count++; s6At = cyc; end
            checkOutput("busy", 64'(busy), 64'(!done));
            if (out_valid) begin
                if (firstValid < 0) firstValid = cyc;
                checkOutput("no read while valid", 64'(mem_rd_en), 64'(0));
                if (held) begin
                    checkOutput("stall y2n", 64'(y2n), 64'(hy0));
                    checkOutput("stall y2n_1", 64'(y2n_1), 64'(hy1));
                    checkOutput("stall y2na", 64'(y2na), 64'(hya));
                    checkOutput("stall s1", 64'(s1), 64'(hs1));
                    checkOutput("stall pair_idx", 64'(pair_idx), 64'(hpi));
                end
                if (out_ready) begin
                    if (n < NP) begin
                        checkOutput("y2n", 64'(y2n), 64'(ey0[n]));
                        checkOutput("y2n_1", 64'(y2n_1), 64'(ey1[n]));
                        checkOutput("y2na", 64'(y2na), 64'(eya[n]));
                        checkOutput("pair_idx", 64'(pair_idx), 64'(n));
                        checkOutput("s1", 64'(s1), 64'({n == NP - 1, n == 0}));
                        checkOutput("s3", 64'(s3), 64'(n == 0));
                        checkOutput("s4", 64'(s4), 64'(n == NP - 1));
                        checkOutput("s5", 64'(s5), 64'(2 * n + 2 == NS));
                    end
                    checkOutput("s2 on transfer", 64'(s2), 64'(1));
                    n++;
                    held = 0;
                end else begin
                    stalls++;
                    checkOutput("s2 while stalled", 64'(s2), 64'(0));
                    held = 1;
                    hy0 = y2n; hy1 = y2n_1; hya = y2na; hs1 = s1; hpi = pair_idx;
                end
            end else begin
                checkOutput("selects idle", 64'({s2, s3, s4, s5}), 64'(0));
            end
            if (done) begin
                doneCycle = cyc;
                start = 1'b0;
                checkOutput("pairs before done", 64'(n), 64'(NP));
            end
            @(posedge clk); #1;
        end

        if (doneCycle < 0) checkOutput("done timeout", 64'(0), 64'(1));
        checkOutput("first valid cycle", 64'(firstValid), 64'(5));
        checkOutput("done cycle", 64'(doneCycle), 64'(5 * NP + 1 + stalls));
        checkOutput("s6 pulses", 64'(s6Count), 64'(1));
        checkOutput("s6 cycle", 64'(s6At), 64'(1));
        if (mode == 2) checkOutput("stall cycles", 64'(stalls), 64'(7));
        checkOutput("read count", 64'(gotAddr.size()), 64'(expAddr.size()));
        for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++)
            checkOutput("read addr", 64'(gotAddr[i]), 64'(expAddr[i]));

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sawRead |= mem_rd_en;
            sawDone |= done;
            sawBusy |= busy;
        end
        checkOutput("idle after frame", 64'({sawRead, sawDone, sawBusy}), 64'(0));
        checkOutput("pair_idx holds", 64'(pair_idx), 64'(NP - 1));
        @(posedge clk); #1;
    endtask

    task automatic resetMidFrame();
        bit sawDone = 0, sawRead = 0;
        for (int i = 0; i < NS; i++) ram[i] = DW'(i + 1);
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("fetch2 pair2 addr", 64'(mem_addr), 64'(6));
        checkOutput("fetch2 pair2 idx", 64'(pair_idx), 64'(2));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkIdleZero("mid-frame reset");
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            sawDone |= done;
            sawRead |= mem_rd_en;
        end
        checkOutput("abandoned frame quiet", 64'({sawDone, sawRead}), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic singlePair();
        int            gotAddr[$];
        int            doneCycle = -1;
        logic [DW-1:0] a, b;
        bit            seenValid = 0;
        a = $urandom;
        b = $urandom;
        ram[0] = a;
        ram[1] = b;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int cyc = 1; cyc <= 40 && doneCycle < 0; cyc++) begin
            @(negedge clk);
            if (mem_rd_en_b) gotAddr.push_back(int'(mem_addr_b));
            if (out_valid_b) begin
                seenValid = 1;
                checkOutput("single y", {y2n_b[31:0], y2n_1_b[31:0]}, {a, b});
                checkOutput("single y2na", 64'(y2na_b), 64'(a));
                checkOutput("single selects", 64'({s1_b, s2_b, s3_b, s4_b, s5_b}), 64'(6'b111111));
            end
            if (done_b) doneCycle = cyc;
            @(posedge clk); #1;
        end
        checkOutput("single saw valid", 64'(seenValid), 64'(1));
        checkOutput("single done cycle", 64'(doneCycle), 64'(6));
        checkOutput("single reads", 64'(gotAddr.size()), 64'(3));
        if (gotAddr.size() == 3)
            checkOutput("single read addrs", 64'({gotAddr[0][3:0], gotAddr[1][3:0], gotAddr[2][3:0]}),
                        64'(12'h010));
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b1;
        out_ready   = 1'b0;
        start_b     = 1'b1;
        out_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkIdleZero("reset");
        checkOutput("reset single busy", 64'({busy_b, done_b, mem_rd_en_b, out_valid_b}), 64'(0));
        @(posedge clk); #1;
        start   = 1'b0;
        start_b = 1'b0;
        rst_n   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkIdleZero("idle after reset");
        @(posedge clk); #1;

        applyStimulus(0, 1'b0);
        applyStimulus(2, 1'b0);
        applyStimulus(0, 1'b1);
        resetMidFrame();
        applyStimulus(0, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(1, 1'b0);
        singlePair();
        singlePair();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
